// File: rtl/sim_exit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sim_exit_monitor
// Purpose  : End-of-computation monitor for NUM_CH independent done/exit-code
//            channels (typically one per hardware thread). Each done line is
//            debounced, per-channel exit codes are captured, and a global
//            PASS / FAIL / TIMEOUT verdict is reported with a cycle watchdog.
// Ports    :
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   enable_i          arms the monitor; low forces IDLE and clears all state
//   timeout_i         watchdog limit in cycles (0 = off), sampled on IDLE->RUN
//   done_i            per-channel end-of-computation flags
//   code_i            per-channel exit codes, channel k at [k*CODE_W +: CODE_W]
//   busy_o            high while running
//   finished_o        high in DONE or TIMEOUT
//   status_o          00 idle/running, 01 PASS, 10 FAIL, 11 TIMEOUT
//   done_mask_o       channels latched as done
//   fail_mask_o       latched channels with a nonzero code
//   first_fail_ch_o   index of the first failing channel
//   first_fail_code_o exit code of that channel
//   cycle_cnt_o       cycles spent in RUN (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module sim_exit_monitor #(
  parameter int NUM_CH        = 3,
  parameter int CODE_W        = 8,
  parameter int CNT_W         = 32,
  parameter int STABLE_CYCLES = 4,
  localparam int FF_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic [CNT_W-1:0]         timeout_i,
  input  logic [NUM_CH-1:0]        done_i,
  input  logic [NUM_CH*CODE_W-1:0] code_i,
  output logic                     busy_o,
  output logic                     finished_o,
  output logic [1:0]               status_o,
  output logic [NUM_CH-1:0]        done_mask_o,
  output logic [NUM_CH-1:0]        fail_mask_o,
  output logic [FF_W-1:0]          first_fail_ch_o,
  output logic [CODE_W-1:0]        first_fail_code_o,
  output logic [CNT_W-1:0]         cycle_cnt_o
);

  // Width of the per-channel debounce counter: it only needs to reach
  // STABLE_CYCLES-1, the latch happens on the following high cycle.
  localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] c_STABLE_LAST = SC_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] c_ST_NONE    = 2'b00;
  localparam logic [1:0] c_ST_PASS    = 2'b01;
  localparam logic [1:0] c_ST_FAIL    = 2'b10;
  localparam logic [1:0] c_ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_DONE    = 2'b10,
    S_TIMEOUT = 2'b11
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    tmo_q;
  logic [CNT_W-1:0]    cycle_cnt_q;
  logic [CNT_W-1:0]    cycle_cnt_d;
  logic [NUM_CH-1:0]   done_mask_q;
  logic [NUM_CH-1:0]   fail_mask_q;
  logic [FF_W-1:0]     ff_ch_q;
  logic [CODE_W-1:0]   ff_code_q;
  logic                busy_q;
  logic                finished_q;
  logic [1:0]          status_q;

  logic [NUM_CH-1:0]   w_latch;    // channel qualifies this cycle
  logic [NUM_CH-1:0]   w_fail;     // qualifying channel carries a nonzero code
  logic                w_ff_hit;
  logic [FF_W-1:0]     w_ff_ch;
  logic [CODE_W-1:0]   w_ff_code;
  logic                w_all_done;
  logic                w_tmo_hit;

  // --------------------------------------------------------------------------
  // Per-channel debounce. The counter is held at zero outside RUN and once
  // the channel has latched, so later done_i/code_i activity is ignored.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [SC_W-1:0]   stab_q;
    logic [CODE_W-1:0] w_code;

    assign w_code     = code_i[k*CODE_W +: CODE_W];
    assign w_latch[k] = (state_q == S_RUN) && !done_mask_q[k] &&
                        done_i[k] && (stab_q == c_STABLE_LAST);
    assign w_fail[k]  = w_latch[k] && (w_code != '0);

    always_ff @(posedge clk) begin
      if (rst || !enable_i || (state_q != S_RUN) || done_mask_q[k]) begin
        stab_q <= '0;
      end else if (!done_i[k]) begin
        stab_q <= '0;
      end else if (stab_q != c_STABLE_LAST) begin
        stab_q <= stab_q + SC_W'(1);
      end
    end
  end

  // Lowest-index failing channel among those latching this cycle: scan from
  // the top so the lowest index overwrites last.
  always_comb begin
    w_ff_hit  = 1'b0;
    w_ff_ch   = '0;
    w_ff_code = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_fail[k]) begin
        w_ff_hit  = 1'b1;
        w_ff_ch   = FF_W'(k);
        w_ff_code = code_i[k*CODE_W +: CODE_W];
      end
    end
  end

  assign cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

  // Completion is judged on the registered mask, so the verdict appears one
  // cycle after the final latch update. When the mask fills in the same cycle
  // the watchdog expires, completion takes priority.
  assign w_all_done = &done_mask_q;
  assign w_tmo_hit  = (tmo_q != '0) && (cycle_cnt_q == tmo_q - CNT_W'(1));

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !enable_i) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      cycle_cnt_q <= '0;
      done_mask_q <= '0;
      fail_mask_q <= '0;
      ff_ch_q     <= '0;
      ff_code_q   <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      status_q    <= c_ST_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_RUN;
          tmo_q   <= timeout_i;
          busy_q  <= 1'b1;
        end

        S_RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          done_mask_q <= done_mask_q | w_latch;
          fail_mask_q <= fail_mask_q | w_fail;
          // First fail is taken only while no failure has been recorded yet.
          if (w_ff_hit && (fail_mask_q == '0)) begin
            ff_ch_q   <= w_ff_ch;
            ff_code_q <= w_ff_code;
          end
          if (w_all_done) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
            status_q   <= (fail_mask_q == '0) ? c_ST_PASS : c_ST_FAIL;
          end else if (w_tmo_hit) begin
            state_q    <= S_TIMEOUT;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
            status_q   <= c_ST_TIMEOUT;
          end
        end

        default: begin
          // DONE and TIMEOUT are sticky until enable_i drops.
          state_q <= state_q;
        end
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign finished_o        = finished_q;
  assign status_o          = status_q;
  assign done_mask_o       = done_mask_q;
  assign fail_mask_o       = fail_mask_q;
  assign first_fail_ch_o   = ff_ch_q;
  assign first_fail_code_o = ff_code_q;
  assign cycle_cnt_o       = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_exit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_exit_monitor
// Purpose  : Scoreboard bench for sim_exit_monitor (NUM_CH=3, CODE_W=8,
//            CNT_W=32, STABLE_CYCLES=4). Stimulus queues expected output
//            snapshots at given cycles and expected verdicts; a monitor pops
//            and compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_exit_monitor;

  localparam int NUM_CH = 3;
  localparam int CODE_W = 8;
  localparam int CNT_W  = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable_i;
  logic [CNT_W-1:0]         timeout_i;
  logic [NUM_CH-1:0]        done_i;
  logic [NUM_CH*CODE_W-1:0] code_i;
  logic                     busy_o;
  logic                     finished_o;
  logic [1:0]               status_o;
  logic [NUM_CH-1:0]        done_mask_o;
  logic [NUM_CH-1:0]        fail_mask_o;
  logic [1:0]               first_fail_ch_o;
  logic [CODE_W-1:0]        first_fail_code_o;
  logic [CNT_W-1:0]         cycle_cnt_o;

  sim_exit_monitor #(
    .NUM_CH        (NUM_CH),
    .CODE_W        (CODE_W),
    .CNT_W         (CNT_W),
    .STABLE_CYCLES (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable_i          (enable_i),
    .timeout_i         (timeout_i),
    .done_i            (done_i),
    .code_i            (code_i),
    .busy_o            (busy_o),
    .finished_o        (finished_o),
    .status_o          (status_o),
    .done_mask_o       (done_mask_o),
    .fail_mask_o       (fail_mask_o),
    .first_fail_ch_o   (first_fail_ch_o),
    .first_fail_code_o (first_fail_code_o),
    .cycle_cnt_o       (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen; stable between edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector: {busy, finished, status, done_mask, fail_mask,
  //                          first_fail_ch, first_fail_code, cycle_cnt}
  typedef struct {
    int          cyc;
    string       name;
    logic [51:0] v;
  } exp_t;

  exp_t snap_q[$];
  exp_t fin_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [51:0] c_ZERO = '0;

  function automatic logic [51:0] pack(input logic b, input logic f,
                                       input logic [1:0] st, input logic [2:0] dm,
                                       input logic [2:0] fm, input logic [1:0] fch,
                                       input logic [7:0] fc, input logic [31:0] cnt);
    return {b, f, st, dm, fm, fch, fc, cnt};
  endfunction

  // Snapshot expectations are kept sorted by cycle.
  task automatic expect_at(input int c, input string n, input logic [51:0] v);
    exp_t e;
    int   pos;
    e.cyc = c; e.name = n; e.v = v;
    pos = snap_q.size();
    for (int i = 0; i < snap_q.size(); i++) begin
      if (snap_q[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    snap_q.insert(pos, e);
  endtask

  task automatic expect_fin(input int c, input string n, input logic [51:0] v);
    exp_t e;
    e.cyc = c; e.name = n; e.v = v;
    fin_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // --------------------------------------------------------------------------
  // Monitor: samples on the falling edge.
  // --------------------------------------------------------------------------
  logic fin_prev = 1'b0;
  always @(negedge clk) begin : mon
    logic [51:0] act;
    exp_t        e;
    act = {busy_o, finished_o, status_o, done_mask_o, fail_mask_o,
           first_fail_ch_o, first_fail_code_o, cycle_cnt_o};
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      e = snap_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: snapshot for cycle %0d not taken (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.v) begin
        errors++;
        $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.v);
      end
    end
    if (finished_o === 1'b1 && fin_prev !== 1'b1) begin
      checks++;
      if (fin_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_finish: cycle %0d got %h expected no verdict", cyc, act);
      end else begin
        e = fin_q.pop_front();
        if (e.cyc != cyc || act !== e.v) begin
          errors++;
          $display("FAIL %s: cycle %0d got %h expected cycle %0d value %h",
                   e.name, cyc, act, e.cyc, e.v);
        end
      end
    end
    fin_prev = finished_o;
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    int r;
    rst       = 1'b1;
    enable_i  = 1'b0;
    timeout_i = '0;
    done_i    = '0;
    code_i    = '0;

    tick(); tick(); tick();
    rst = 1'b0;
    expect_at(cyc,     "reset_state", c_ZERO);
    expect_at(cyc + 1, "idle_after_reset", c_ZERO);
    goto_cyc(5);

    // ---- All pass, watchdog disabled ----
    enable_i = 1'b1;
    r = cyc + 1;
    expect_at(r,      "t1_run_start",  pack(1, 0, 2'b00, 3'b000, 3'b000, 2'd0, 8'h00, 0));
    expect_at(r + 14, "t1_latched",    pack(1, 0, 2'b00, 3'b111, 3'b000, 2'd0, 8'h00, 14));
    expect_fin(r + 15, "t1_pass",      pack(0, 1, 2'b01, 3'b111, 3'b000, 2'd0, 8'h00, 15));
    expect_at(r + 18, "t1_frozen",     pack(0, 1, 2'b01, 3'b111, 3'b000, 2'd0, 8'h00, 15));
    expect_at(r + 19, "t1_idle",       c_ZERO);
    goto_cyc(r + 10);
    done_i = 3'b111;
    goto_cyc(r + 18);
    enable_i = 1'b0;
    done_i   = '0;
    goto_cyc(r + 20);

    // ---- Two fails in one cycle, then code changes after latch ----
    enable_i = 1'b1;
    code_i   = {8'h07, 8'h05, 8'h33};
    r = cyc + 1;
    expect_at(r + 9,  "t2_two_fail",   pack(1, 0, 2'b00, 3'b110, 3'b110, 2'd1, 8'h05, 9));
    expect_at(r + 13, "t6_code_hold",  pack(1, 0, 2'b00, 3'b110, 3'b110, 2'd1, 8'h05, 13));
    expect_fin(r + 17, "t2_fail",      pack(0, 1, 2'b10, 3'b111, 3'b110, 2'd1, 8'h05, 17));
    expect_at(r + 20, "t2_idle",       c_ZERO);
    goto_cyc(r + 5);
    done_i = 3'b110;
    goto_cyc(r + 10);
    code_i = {8'h00, 8'h00, 8'h33};
    goto_cyc(r + 12);
    done_i = 3'b111;
    code_i = '0;
    goto_cyc(r + 19);
    enable_i = 1'b0;
    done_i   = '0;
    goto_cyc(r + 21);

    // ---- Debounce, then abort mid-run ----
    timeout_i = 100;
    enable_i  = 1'b1;
    r = cyc + 1;
    expect_at(r + 6,  "t3_glitch_ignored", pack(1, 0, 2'b00, 3'b000, 3'b000, 2'd0, 8'h00, 6));
    expect_at(r + 9,  "t3_not_yet",        pack(1, 0, 2'b00, 3'b000, 3'b000, 2'd0, 8'h00, 9));
    expect_at(r + 10, "t3_latched",        pack(1, 0, 2'b00, 3'b001, 3'b000, 2'd0, 8'h00, 10));
    expect_at(r + 13, "t5_abort_idle",     c_ZERO);
    goto_cyc(r + 2);
    done_i = 3'b001;
    goto_cyc(r + 5);
    done_i = 3'b000;
    goto_cyc(r + 6);
    done_i = 3'b001;
    goto_cyc(r + 12);
    enable_i = 1'b0;
    done_i   = '0;
    goto_cyc(r + 14);

    // ---- Re-arm into watchdog run: only channels 0 and 1 finish ----
    enable_i = 1'b1;
    r = cyc + 1;
    expect_at(r,      "t5_rearm_cnt0",  pack(1, 0, 2'b00, 3'b000, 3'b000, 2'd0, 8'h00, 0));
    expect_at(r + 99, "t4_before_tmo",  pack(1, 0, 2'b00, 3'b011, 3'b010, 2'd1, 8'h09, 99));
    expect_fin(r + 100, "t4_timeout",   pack(0, 1, 2'b11, 3'b011, 3'b010, 2'd1, 8'h09, 100));
    expect_at(r + 103, "t4_idle",       c_ZERO);
    goto_cyc(r + 3);
    done_i = 3'b011;
    code_i = {8'h00, 8'h09, 8'h00};
    goto_cyc(r + 102);
    enable_i = 1'b0;
    done_i   = '0;
    code_i   = '0;
    goto_cyc(r + 104);

    // ---- Last latch lands on the watchdog cycle: DONE wins; reset in DONE ----
    enable_i = 1'b1;
    r = cyc + 1;
    expect_at(r + 99, "t4_last_latch_c99", pack(1, 0, 2'b00, 3'b111, 3'b000, 2'd0, 8'h00, 99));
    expect_fin(r + 100, "t4_done_wins",    pack(0, 1, 2'b01, 3'b111, 3'b000, 2'd0, 8'h00, 100));
    expect_at(r + 102, "t5_done_frozen",   pack(0, 1, 2'b01, 3'b111, 3'b000, 2'd0, 8'h00, 100));
    expect_at(r + 104, "t5_reset_in_done", c_ZERO);
    goto_cyc(r + 95);
    done_i = 3'b111;
    goto_cyc(r + 103);
    rst = 1'b1;
    goto_cyc(r + 104);
    rst      = 1'b0;
    enable_i = 1'b0;
    done_i   = '0;
    goto_cyc(r + 107);

    // Every queued expectation must have been consumed.
    while (snap_q.size() > 0) begin
      exp_t e;
      e = snap_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: snapshot never taken, expected %h at cycle %0d", e.name, e.v, e.cyc);
    end
    while (fin_q.size() > 0) begin
      exp_t e;
      e = fin_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: verdict never seen, expected %h at cycle %0d", e.name, e.v, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_exit_monitor.md
# sim_exit_monitor

Synthesizable, parametrised end-of-computation monitor for the PULPino/Klessydra platform. It replaces the single-pin "wait for gpio_out[8], then read the return codes" scheme with one that handles NUM_CH independent done/exit-code channels, typically one per hardware thread. Each done line is debounced, per-channel exit codes are captured, and the block reports a global PASS/FAIL/TIMEOUT verdict with a cycle-accurate watchdog. It sits between the core's GPIO/CSR outputs and the testbench, or an FPGA status LED/UART reporter.

## Interface
- NUM_CH, default 3: number of monitored channels (≥1).
- CODE_W, default 8: exit-code width per channel (≥1).
- CNT_W, default 32: cycle counter and timeout width.
- STABLE_CYCLES, default 4: consecutive high cycles required on done_i[k] to qualify (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable_i  in  1  arms the monitor. Low forces IDLE.
- timeout_i  in  CNT_W  watchdog limit in cycles. 0 disables the watchdog. Sampled on the IDLE→RUN transition.
- done_i  in  NUM_CH  per-channel end-of-computation flag.
- code_i  in  NUM_CH*CODE_W  per-channel exit code. Channel k occupies bits [k*CODE_W +: CODE_W].
- busy_o  out  1  high in RUN.
- finished_o  out  1  high in DONE or TIMEOUT.
- status_o  out  2  00 running/idle, 01 PASS, 10 FAIL, 11 TIMEOUT.
- done_mask_o  out  NUM_CH  channels latched as done.
- fail_mask_o  out  NUM_CH  latched channels with nonzero code.
- first_fail_ch_o  out  $clog2(NUM_CH) (min 1)  index of the first failing channel.
- first_fail_code_o  out  CODE_W  code of that channel.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN.

## Operation
- **States:** IDLE, RUN, DONE, TIMEOUT.
- **IDLE:** all registers cleared. enable_i=1 → RUN next cycle. timeout_i is captured into tmo_q on this transition.
- **RUN:**
  - cycle_cnt increments every cycle and saturates at all-ones.
  - Each channel has a stable counter, cleared whenever done_i[k]=0 and incremented while done_i[k]=1.
  - When the counter reaches STABLE_CYCLES, the channel latches: done_mask[k]←1, its code is captured from code_i in that same cycle, and fail_mask[k]←(code≠0).
  - A latched channel ignores all further done_i/code_i activity.
- **First fail:** recorded once, on the first cycle in which any latching channel has a nonzero code. If several fail in that same cycle, the lowest index wins.
- **RUN → DONE:** when done_mask becomes all-ones. status_o = PASS if fail_mask=0, otherwise FAIL.
- **RUN → TIMEOUT:** when tmo_q≠0 and cycle_cnt reaches tmo_q-1 (RUN lasted tmo_q cycles) and not all channels are done. status_o=11. done_mask and fail_mask keep their partial values.
- **Simultaneous completion and timeout:** if the last channel latches in the same cycle the timeout fires, DONE wins.
- **DONE/TIMEOUT:** sticky. All outputs frozen. The block returns to IDLE only when enable_i=0.
- **enable_i=0 in RUN:** aborts to IDLE next cycle and clears all state.
- **Reset:** rst in any state → IDLE next edge. All outputs are 0 after reset.

## Timing
- Reset values: every output is 0, including status_o=00 and cycle_cnt_o=0.
- enable_i rising in IDLE → busy_o=1 on the next cycle. cycle_cnt_o=0 in the first RUN cycle.
- Latch latency: if done_i[k] first goes high at cycle t, done_mask_o[k]=1 at t+STABLE_CYCLES. The captured code is code_i at t+STABLE_CYCLES-1.
- finished_o and status_o become valid 1 cycle after the final latch register update, i.e. registered from the state. busy_o falls in the same cycle.
- Timeout: finished_o rises exactly tmo_q cycles after busy_o rose.
- A glitch on done_i shorter than STABLE_CYCLES cycles never latches.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
1. **All pass.** NUM_CH=3, STABLE_CYCLES=4, timeout_i=0. Raise done_i=111 with codes 0 at cycle 10 of RUN → done_mask=111 at cycle 14, status_o=01 at cycle 15, cycle_cnt_o frozen at 15.
2. **Multiple fails in one cycle.** Channels 1 and 2 raise done together with codes 0x05 and 0x07; channel 0 finishes later with code 0 → status_o=10, fail_mask_o=110, first_fail_ch_o=1, first_fail_code_o=0x05.
3. **Debounce.** Pulse done_i[0] high for 3 cycles, low for 1, then hold high → latch occurs 4 cycles after the final rise. The first pulse has no effect on done_mask_o.
4. **Watchdog.** timeout_i=100, only channels 0 and 1 finish → status_o=11 with finished_o rising exactly 100 cycles after busy_o, done_mask_o=011. A second run with the last latch landing on cycle 99 → status_o=01 (DONE wins).
5. **Abort and reset.** Drop enable_i mid-RUN → IDLE, all outputs 0, and a re-arm restarts cycle_cnt at 0. Assert rst in DONE → all outputs 0 on the next edge.
6. **Code capture.** Change code_i[k] after channel k has latched → captured code and fail_mask are unchanged.
